// File: rtl/key_matrix_pkg.sv
// key_matrix_pkg: shared constants and debounce state type for the key matrix scanner
package key_matrix_pkg;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 5;
  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] KEY_NONE = 5'd31;
  typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} db_state_t;
endpackage

// File: rtl/key_matrix_scan_if.sv
// key_matrix_scan_if: keypad matrix drive/return plus accepted-key outputs
interface key_matrix_scan_if;
  import key_matrix_pkg::*;
  logic [NUM_COLS-1:0] key_out;
  logic [NUM_ROWS-1:0] key_in;
  logic [CODE_W-1:0] key_code;
  logic key_valid;
  logic key_held;
  modport master(output key_out, key_code, key_valid, key_held, input key_in);
  modport slave(input key_out, key_code, key_valid, key_held, output key_in);
endinterface

// File: rtl/key_matrix_sync.sv
// key_matrix_sync: 2-flop synchronizer for the asynchronous row returns
module key_matrix_sync #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      meta <= '0;
      q <= '0;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x5 key matrix column scanner with frame-based debounce.
// Optional auto-repeat strobes are built when KEY_MATRIX_SCAN_REPEAT_EN is defined.
module key_matrix_scan
  import key_matrix_pkg::*;
#(
  parameter int SCAN_DIV = 10000,
  parameter int DEBOUNCE_FRAMES = 10,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE = 10
) (
  input logic i_clk,
  input logic i_rstn,
  key_matrix_scan_if.master kp
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  if (SCAN_DIV < 4) begin : g_bad_div
    $error("SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_FRAMES < 1) begin : g_bad_db
    $error("DEBOUNCE_FRAMES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rep
    $error("REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end
  logic [NUM_ROWS-1:0] rows;
  logic [DIV_W-1:0] dwell;
  logic [1:0] col, acc_n, nxt_n;
  logic [2:0] row_n, tot;
  logic [CODE_W-1:0] acc_code, row_code, nxt_code, cand, code, code_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  db_state_t st, st_n;
  logic sample, frame_end, valid, valid_n, rep_hit;
  key_matrix_sync #(.W(NUM_ROWS)) u_sync (.i_clk(i_clk), .i_rstn(i_rstn), .d(kp.key_in), .q(rows));
  assign sample = dwell == DIV_W'(SCAN_DIV - 1);
  assign frame_end = sample && col == 2'(NUM_COLS - 1);
  assign kp.key_out = NUM_COLS'(1) << col;
  assign kp.key_held = st == PRESSED || st == RELEASE_PEND;
  assign kp.key_code = kp.key_held ? code : KEY_NONE;
  assign kp.key_valid = valid;
  // Frame candidate: saturating count of asserted rows across the frame; two or more is a ghost
  always_comb begin
    row_n = '0;
    row_code = KEY_NONE;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (rows[r]) begin
        row_n = row_n + 3'd1;
        row_code = {3'(r), col};
      end
    end
    tot = 3'(acc_n) + row_n;
    nxt_n = tot >= 3'd2 ? 2'd2 : tot[1:0];
    nxt_code = row_n == 3'd1 ? row_code : acc_code;
    cand = nxt_n == 2'd1 ? nxt_code : KEY_NONE;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      dwell <= '0;
      col <= '0;
      acc_n <= '0;
      acc_code <= KEY_NONE;
    end else begin
      dwell <= sample ? '0 : dwell + 1'b1;
      if (sample) begin
        col <= col + 2'd1;
        acc_n <= frame_end ? 2'd0 : nxt_n;
        acc_code <= frame_end ? KEY_NONE : nxt_code;
      end
    end
  end
  always_comb begin
    st_n = st;
    code_n = code;
    cnt_n = cnt;
    valid_n = 1'b0;
    cnt_inc = cnt + 1'b1;
    if (frame_end) begin
      case (st)
        RELEASED:
          if (cand != KEY_NONE) begin
            code_n = cand;
            cnt_n = CNT_W'(1);
            st_n = DEBOUNCE_FRAMES <= 1 ? PRESSED : PRESS_PEND;
            valid_n = DEBOUNCE_FRAMES <= 1;
          end
        PRESS_PEND:
          if (cand == KEY_NONE) st_n = RELEASED;
          else if (cand != code) begin
            code_n = cand;
            cnt_n = CNT_W'(1);
          end else begin
            cnt_n = cnt_inc;
            st_n = cnt_inc >= CNT_W'(DEBOUNCE_FRAMES) ? PRESSED : PRESS_PEND;
            valid_n = cnt_inc >= CNT_W'(DEBOUNCE_FRAMES);
          end
        PRESSED:
          if (cand != code) begin
            cnt_n = CNT_W'(1);
            st_n = DEBOUNCE_FRAMES <= 1 ? RELEASED : RELEASE_PEND;
          end
        RELEASE_PEND:
          if (cand == code) st_n = PRESSED;
          else begin
            cnt_n = cnt_inc;
            st_n = cnt_inc >= CNT_W'(DEBOUNCE_FRAMES) ? RELEASED : RELEASE_PEND;
          end
      endcase
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      st <= RELEASED;
      code <= KEY_NONE;
      cnt <= '0;
      valid <= 1'b0;
    end else begin
      st <= st_n;
      code <= code_n;
      cnt <= cnt_n;
      valid <= valid_n | rep_hit;
    end
  end
`ifdef KEY_MATRIX_SCAN_REPEAT_EN
  localparam int REP_MAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(REP_MAX + 1);
  logic [RW-1:0] rep;
  logic rep_on;
  // Counts frames spent continuously in PRESSED; restarts whenever PRESSED is left
  assign rep_hit = frame_end && st == PRESSED && st_n == PRESSED &&
                   (rep + 1'b1) == (rep_on ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY));
  always_ff @(posedge i_clk) begin
    if (!i_rstn || st_n != PRESSED) begin
      rep <= '0;
      rep_on <= 1'b0;
    end else if (frame_end && st == PRESSED) begin
      rep <= rep_hit ? '0 : rep + 1'b1;
      rep_on <= rep_on | rep_hit;
    end
  end
`else
  assign rep_hit = 1'b0;
`endif
endmodule
